// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential signed divider.
// The master issues operations and the slave (the divider) returns results and status.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic                    busy;
  logic                    done;
  logic                    div_by_zero;
  logic                    overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, then sign correction. Fixed latency for every operand pair.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Most negative input maps to 1000..0, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? negate(u) : u;
  endfunction

  // Control state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Registered results
  logic signed [WIDTH-1:0] quotient_q, quotient_d;
  logic signed [WIDTH-1:0] remainder_q, remainder_d;
  logic                    div_by_zero_q, div_by_zero_d;
  logic                    overflow_q, overflow_d;

  // Working data, loaded on every accepted start so it needs no reset
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic signed [WIDTH-1:0] dvd_q, dvd_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    zero_q, zero_d;
  logic                    ovf_q, ovf_d;

  // The kept remainder is always below the divisor magnitude, so only the
  // shifted value and the trial difference need the extra sign bit.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    r_shift = {rem_q, quo_q[WIDTH-1]};
    trial   = r_shift - {1'b0, dvs_q};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_d        = zero_q;
    ovf_d         = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = magnitude(bus.dividend);
          dvs_d     = magnitude(bus.divisor);
          dvd_d     = bus.dividend;
          neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_rem_d = bus.dividend[WIDTH-1];
          zero_d    = (bus.divisor == '0);
          ovf_d     = (bus.dividend == MOST_NEG) && (bus.divisor == ALL_ONE);
        end
      end

      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = r_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d       = IDLE;
        cnt_d         = '0;
        done_d        = 1'b1;
        div_by_zero_d = zero_q;
        overflow_d    = ovf_q;
        if (zero_q) begin
          quotient_d  = ALL_ONE;
          remainder_d = dvd_q;
        end else if (ovf_q) begin
          quotient_d  = MOST_NEG;
          remainder_d = '0;
        end else begin
          quotient_d  = neg_quo_q ? negate(quo_q) : quo_q;
          remainder_d = neg_rem_q ? negate(rem_q) : rem_q;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    dvd_q     <= dvd_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    zero_q    <= zero_d;
    ovf_q     <= ovf_d;
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.overflow    = overflow_q;
endmodule
